// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the frame-RAM write-side control: FSM encodings,
// requester indices and the address-width convention used by RAM and renderers.
package ram_ctrl_pkg;

  localparam logic [0:0] S_SERVE = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ram_wr_scheduler_rr_arbiter2.sv
// Two-way round-robin grant: on contention the requester that did not win last
// time is granted; grants are one-hot and forced low when disabled.
module rr_arbiter2
  import ram_ctrl_pkg::*;
(
  input  logic i_En,
  input  logic i_Valid0,
  input  logic i_Valid1,
  input  logic i_Last_Grant,
  output logic o_Grant0,
  output logic o_Grant1
);

  assign o_Grant0 = i_En & i_Valid0 & (~i_Valid1 | (i_Last_Grant == REQ1));
  assign o_Grant1 = i_En & i_Valid1 & (~i_Valid0 | (i_Last_Grant == REQ0));

endmodule

// File: rtl/ram_wr_scheduler.sv
// Write-port controller for the frame RAM: round-robin sharing between two
// renderers plus a full-memory clear sweep, all in the write-clock domain.
module ram_wr_scheduler
  import ram_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 4,
  parameter int                    ADDR_DEPTH  = 32,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
)(
  input  logic                          i_Wr_Clk,
  input  logic                          i_RST,
  input  logic                          i_Req0_Valid,
  input  logic [$clog2(ADDR_DEPTH)-1:0] i_Req0_Addr,
  input  logic [DATA_WIDTH-1:0]         i_Req0_Data,
  output logic                          o_Req0_Ready,
  input  logic                          i_Req1_Valid,
  input  logic [$clog2(ADDR_DEPTH)-1:0] i_Req1_Addr,
  input  logic [DATA_WIDTH-1:0]         i_Req1_Data,
  output logic                          o_Req1_Ready,
  input  logic                          i_Clear_Start,
  output logic                          o_Clear_Busy,
  output logic                          o_Clear_Done,
  output logic                          o_Wr_En,
  output logic [$clog2(ADDR_DEPTH)-1:0] o_Wr_Addr,
  output logic [DATA_WIDTH-1:0]         o_Wr_Data
);

  localparam int                ADDR_W    = addr_w(ADDR_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ADDR_DEPTH - 1);

  logic [0:0]            r_State;
  logic                  r_Last_Grant;
  logic [ADDR_W-1:0]     r_Clr_Cnt;
  logic                  r_Wr_En;
  logic [ADDR_W-1:0]     r_Wr_Addr;
  logic [DATA_WIDTH-1:0] r_Wr_Data;
  logic                  r_Clear_Busy;
  logic                  r_Clear_Done;

  logic w_Arb_En;
  logic w_Grant0;
  logic w_Grant1;

  // Reset also masks the combinational Ready so every output is low during reset.
  assign w_Arb_En = (r_State == S_SERVE) & ~i_Clear_Start & ~i_RST;

  rr_arbiter2 u_arb (
    .i_En         (w_Arb_En),
    .i_Valid0     (i_Req0_Valid),
    .i_Valid1     (i_Req1_Valid),
    .i_Last_Grant (r_Last_Grant),
    .o_Grant0     (w_Grant0),
    .o_Grant1     (w_Grant1)
  );

  always_ff @(posedge i_Wr_Clk or posedge i_RST) begin
    if (i_RST) begin
      r_State      <= S_SERVE;
      r_Last_Grant <= REQ1;
      r_Clr_Cnt    <= '0;
      r_Wr_En      <= 1'b0;
      r_Wr_Addr    <= '0;
      r_Wr_Data    <= '0;
      r_Clear_Busy <= 1'b0;
      r_Clear_Done <= 1'b0;
    end else begin
      r_Wr_En      <= 1'b0;
      r_Clear_Done <= 1'b0;
      if (r_State == S_SERVE) begin
        if (i_Clear_Start) begin
          r_State      <= S_CLEAR;
          r_Clr_Cnt    <= '0;
          r_Clear_Busy <= 1'b1;
        end else if (w_Grant0 | w_Grant1) begin
          r_Wr_En      <= 1'b1;
          r_Wr_Addr    <= w_Grant1 ? i_Req1_Addr : i_Req0_Addr;
          r_Wr_Data    <= w_Grant1 ? i_Req1_Data : i_Req0_Data;
          r_Last_Grant <= w_Grant1 ? REQ1 : REQ0;
        end
      end else begin
        r_Wr_En   <= 1'b1;
        r_Wr_Addr <= r_Clr_Cnt;
        r_Wr_Data <= CLEAR_VALUE;
        // The counter stops at the last word; it is reloaded on the next clear start.
        if (r_Clr_Cnt == LAST_ADDR) begin
          r_State      <= S_SERVE;
          r_Clear_Busy <= 1'b0;
          r_Clear_Done <= 1'b1;
        end else begin
          r_Clr_Cnt <= r_Clr_Cnt + 1'b1;
        end
      end
    end
  end

  assign o_Req0_Ready = w_Grant0;
  assign o_Req1_Ready = w_Grant1;
  assign o_Clear_Busy = r_Clear_Busy;
  assign o_Clear_Done = r_Clear_Done;
  assign o_Wr_En      = r_Wr_En;
  assign o_Wr_Addr    = r_Wr_Addr;
  assign o_Wr_Data    = r_Wr_Data;

endmodule

// File: tb/tb_ram_wr_scheduler.sv
// Bench for ram_wr_scheduler: behavioural model checked every cycle, directed
// scenarios with literal expectations, randomized requester traffic and clears.
module tb_ram_wr_scheduler;

  localparam int        D  = 32;
  localparam int        AW = 5;
  localparam logic [3:0] CV = 4'h0;

  logic          clk = 1'b0;
  logic          rst;
  logic          v0, v1, cs;
  logic [AW-1:0] a0, a1;
  logic [3:0]    d0, d1;
  logic          r0, r1, busy, done, we;
  logic [AW-1:0] wa;
  logic [3:0]    wd;
  logic          preload;

  always #5 clk = ~clk;

  ram_wr_scheduler #(.DATA_WIDTH(4), .ADDR_DEPTH(D), .CLEAR_VALUE(CV)) dut (
    .i_Wr_Clk(clk), .i_RST(rst),
    .i_Req0_Valid(v0), .i_Req0_Addr(a0), .i_Req0_Data(d0), .o_Req0_Ready(r0),
    .i_Req1_Valid(v1), .i_Req1_Addr(a1), .i_Req1_Data(d1), .o_Req1_Ready(r1),
    .i_Clear_Start(cs), .o_Clear_Busy(busy), .o_Clear_Done(done),
    .o_Wr_En(we), .o_Wr_Addr(wa), .o_Wr_Data(wd)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // The RAM the scheduler drives (write side only).
  logic [3:0] ram [0:D-1];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < D; i++) ram[i] <= 4'hF;
    end else if (we) begin
      ram[wa] <= wd;
    end
  end

  int done_cnt = 0;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  // Behavioural model: expected registered outputs for the current cycle.
  int   m_last = 1, m_caddr = 0, m_addr = 0, m_data = 0;
  bit   m_clear = 0, m_we = 0, m_done = 0;
  int   n_last, n_caddr, n_addr, n_data;
  bit   n_clear, n_we, n_done;
  int   cyc = 0, n_tag = -1;
  logic xfer0 = 1'b0, xfer1 = 1'b0;

  always @(negedge clk) begin : mon
    int win;
    if (rst === 1'b0) begin
      chk("mon_wr_en", we, m_we);
      if (m_we) begin
        chk("mon_wr_addr", wa, m_addr);
        chk("mon_wr_data", wd, m_data);
      end
      chk("mon_busy", busy, m_clear);
      chk("mon_done", done, m_done);
      win = -1;
      if (m_clear) begin
        n_we <= 1; n_addr <= m_caddr; n_data <= CV;
        n_clear <= (m_caddr != D - 1); n_done <= (m_caddr == D - 1);
        n_caddr <= m_caddr + 1; n_last <= m_last;
      end else if (cs) begin
        n_we <= 0; n_clear <= 1; n_caddr <= 0; n_done <= 0;
        n_last <= m_last; n_addr <= m_addr; n_data <= m_data;
      end else begin
        if (v0 && v1) win = 1 - m_last;
        else if (v0) win = 0;
        else if (v1) win = 1;
        n_clear <= 0; n_done <= 0; n_caddr <= m_caddr;
        n_we   <= (win >= 0);
        n_addr <= (win == 1) ? int'(a1) : int'(a0);
        n_data <= (win == 1) ? int'(d1) : int'(d0);
        n_last <= (win < 0) ? m_last : win;
      end
      chk("mon_rdy0", r0, (win == 0));
      chk("mon_rdy1", r1, (win == 1));
      xfer0 <= v0 & r0;
      xfer1 <= v1 & r1;
      n_tag <= cyc;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_we <= 0; m_clear <= 0; m_done <= 0; m_last <= 1;
      m_caddr <= 0; m_addr <= 0; m_data <= 0;
      cyc <= cyc + 1;
    end else begin
      if (n_tag == cyc) begin
        m_we <= n_we; m_clear <= n_clear; m_done <= n_done; m_last <= n_last;
        m_caddr <= n_caddr; m_addr <= n_addr; m_data <= n_data;
      end
      cyc <= cyc + 1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rand_cycle();
    if (!v0 || xfer0) begin
      v0 = ($urandom_range(0, 3) != 0); a0 = AW'($urandom_range(0, D - 1)); d0 = 4'($urandom);
    end
    if (!v1 || xfer1) begin
      v1 = ($urandom_range(0, 3) != 0); a1 = AW'($urandom_range(0, D - 1)); d1 = 4'($urandom);
    end
    cs = ($urandom_range(0, 59) == 0);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdy0"}, r0, 0);
    chk({tag, "_rdy1"}, r1, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, k1, nb, nd, na, nr, got, cnt, dsnap;
    rst = 1'b1; v0 = 1; v1 = 1; cs = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; preload = 0;
    #1;
    check_all_zero("reset_init");
    v0 = 0; v1 = 0;
    tick(); tick();
    rst = 1'b0;

    // Random traffic, then an asynchronous reset in the middle of it.
    for (int i = 0; i < 200; i++) rand_cycle();
    cs = 0;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_all_zero("reset_stream");
    @(posedge clk); #1;
    rst = 1'b0; v0 = 0; v1 = 0; cs = 0;
    tick();

    // Contention: alternation must start with Req0 after reset.
    k0 = 0; k1 = 0;
    v0 = 1; v1 = 1; a0 = 0; d0 = 4'd1; a1 = 16; d1 = 4'd8;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("cont_rdy0", r0, (i % 2 == 0));
      chk("cont_rdy1", r1, (i % 2 == 1));
      if (i > 0) begin
        chk("cont_we", we, 1);
        chk("cont_addr", wa, ((i - 1) % 2 == 0) ? (i - 1) / 2 : 16 + (i - 1) / 2);
      end
      @(posedge clk); #1;
      if (i % 2 == 0) begin k0++; a0 = AW'(k0); d0 = 4'(k0 + 1); end
      else begin k1++; a1 = AW'(16 + k1); d1 = 4'(8 + k1); end
    end
    v0 = 0; v1 = 0;
    @(negedge clk);
    chk("cont_last_addr", wa, 19);
    chk("cont_last_data", wd, 11);
    tick();

    // Single write with one-cycle latency.
    v0 = 1; a0 = 5; d0 = 4'hA;
    @(negedge clk);
    chk("single_rdy0", r0, 1);
    @(posedge clk); #1;
    v0 = 0;
    @(negedge clk);
    chk("single_we", we, 1);
    chk("single_addr", wa, 5);
    chk("single_data", wd, 4'hA);
    @(negedge clk);
    chk("single_we_off", we, 0);
    tick();

    // Full clear over a preloaded RAM.
    preload = 1; tick(); preload = 0;
    cs = 1; tick(); cs = 0;
    nb = 0; nd = 0; na = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) nd++;
      if (we) begin chk("clr_addr_order", wa, na); na++; end
    end
    chk("clr_busy_cycles", nb, 32);
    chk("clr_done_pulses", nd, 1);
    chk("clr_write_count", na, 32);
    cnt = 0;
    for (int i = 0; i < D; i++) if (ram[i] != 4'h0) cnt++;
    chk("clr_ram_nonzero", cnt, 0);
    tick();

    // Clear start colliding with a pending Req1 write.
    cs = 1; v1 = 1; a1 = 3; d1 = 4'h7;
    nr = 0; got = 0;
    for (int i = 0; i < 100 && got == 0; i++) begin
      @(negedge clk);
      if (r1) begin
        got = 1;
        chk("coll_done_with_ready", done, 1);
      end else nr++;
      @(posedge clk); #1;
      cs = 0;
      if (got != 0) v1 = 0;
    end
    chk("coll_accepted", got, 1);
    chk("coll_wait_cycles", nr, 33);
    tick(); tick();
    chk("coll_ram3", ram[3], 4'h7);

    // Second random phase including random clears.
    for (int i = 0; i < 300; i++) rand_cycle();
    v0 = 0; v1 = 0; cs = 0;
    for (int i = 0; i < 40; i++) tick();

    // Reset in the middle of a clear sweep.
    preload = 1; tick(); preload = 0;
    cs = 1; tick(); cs = 0;
    got = 0;
    for (int i = 0; i < 60 && got == 0; i++) begin
      @(negedge clk);
      if (we && wa == 10) got = 1;
    end
    chk("midclr_reached10", got, 1);
    dsnap = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("reset_midclr");
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("midclr_no_done", done_cnt, dsnap);
    cnt = 0;
    for (int i = 11; i < D; i++) if (ram[i] == 4'hF) cnt++;
    chk("midclr_untouched", cnt, 21);
    cnt = 0;
    for (int i = 0; i < 10; i++) if (ram[i] == 4'h0) cnt++;
    chk("midclr_cleared", cnt, 10);

    v0 = 1; a0 = 20; d0 = 4'h5;
    @(negedge clk);
    chk("post_rst_rdy0", r0, 1);
    @(posedge clk); #1;
    v0 = 0;
    tick(); tick();
    chk("post_rst_ram20", ram[20], 4'h5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_wr_scheduler.md
# ram_wr_scheduler

Write-port controller for the dual-clock frame RAM in the attitude-indicator datapath. It shares the RAM write port between two renderers (for example horizon fill and overlay) using a valid/ready handshake with round-robin arbitration. It also runs a full-memory clear sequence on request. All logic is in the write-clock domain; the read port is untouched.

## Interface
Parameters:
- DATA_WIDTH, 4, RAM word width
- ADDR_DEPTH, 32, number of RAM words; need not be a power of two
- CLEAR_VALUE, 0, word written during clear (DATA_WIDTH bits)

Ports (ADDR_W = $clog2(ADDR_DEPTH)):
- Reset is i_RST, asynchronous, active-high; the clock is i_Wr_Clk.
- i_Wr_Clk  in  1  write-domain clock, shared with the RAM write port
- i_RST  in  1  async active-high reset
- i_Req0_Valid  in  1  requester 0 has a write pending
- i_Req0_Addr  in  ADDR_W  requester 0 address
- i_Req0_Data  in  DATA_WIDTH  requester 0 data
- o_Req0_Ready  out  1  requester 0 accepted this cycle
- i_Req1_Valid / i_Req1_Addr / i_Req1_Data / o_Req1_Ready  same as requester 0
- i_Clear_Start  in  1  start clear sequence (level sampled)
- o_Clear_Busy  out  1  clear in progress
- o_Clear_Done  out  1  one-cycle pulse when clear finishes
- o_Wr_En  out  1  to RAM write enable
- o_Wr_Addr  out  ADDR_W  to RAM write address
- o_Wr_Data  out  DATA_WIDTH  to RAM write data

## Operation
- FSM states:
  - S_SERVE: arbitrate requesters.
  - S_CLEAR: sweep all addresses.
- Reset values:
  - State: S_SERVE.
  - r_Last_Grant: 1, so requester 0 wins first.
  - Clear counter: 0.
  - All outputs: 0.
- S_SERVE with i_Clear_Start = 1:
  - Go to S_CLEAR; counter = 0; o_Clear_Busy = 1.
  - No Ready that cycle; clear beats any request.
- S_SERVE arbitration, otherwise:
  - Only one Valid: grant that requester.
  - Both Valid: grant the requester not equal to r_Last_Grant.
  - Ready is asserted only to the granted requester, combinationally in the same cycle.
  - A transfer is Valid & Ready; r_Last_Grant updates on each transfer.
- Requester rule: Valid must not depend on Ready. Once asserted, a requester holds Valid, Addr and Data until the transfer.
- S_CLEAR, each cycle:
  - Register a write of CLEAR_VALUE to the counter address, then increment the counter.
  - On the write of address ADDR_DEPTH-1: return to S_SERVE, o_Clear_Busy = 0, o_Clear_Done = 1 for one cycle.
- In S_CLEAR, both Ready outputs are 0 and i_Clear_Start is ignored.
- Addresses ≥ ADDR_DEPTH from requesters are passed through unchanged; range checking is the requester's responsibility.
- The counter never exceeds ADDR_DEPTH-1; there is no wrap-around.

## Timing
- Request path:
  - Transfer at edge E puts o_Wr_En = 1, o_Wr_Addr and o_Wr_Data on the outputs for the cycle after E. Latency is 1 cycle.
  - o_Wr_En = 0 in every cycle that follows an edge with no transfer and no clear write.
  - Throughput is one write per cycle with no bubble, including when grants alternate between requesters.
- Clear path:
  - i_Clear_Start sampled at edge E0 puts o_Clear_Busy high after E0.
  - Edges E1..E_D (D = ADDR_DEPTH) register writes to addresses 0..D-1. o_Wr_En stays high for D consecutive cycles.
  - At E_D, Busy falls and Done pulses.
  - Requests can be accepted in the cycle after E_D.
  - Total occupancy is D+1 cycles from the start sample.
- Back-to-back clears are allowed: i_Clear_Start held high re-enters S_CLEAR on the first S_SERVE cycle.
- Reset asserted mid-clear or mid-transfer:
  - All outputs go to 0 immediately (asynchronous); the in-flight write is dropped.
  - No o_Clear_Done is generated. RAM contents stay partially cleared.

## Structure
- Shared package/header ram_ctrl_pkg holds:
  - state encodings S_SERVE and S_CLEAR;
  - requester index constants REQ0 and REQ1;
  - the ADDR_W = $clog2(ADDR_DEPTH) convention reused by the RAM and the renderers.
- One sub-module, rr_arbiter2: a two-way round-robin grant. Inputs are the two Valid signals, the last-grant bit and an enable; outputs are one-hot grants. The FSM gates its enable with S_SERVE and !i_Clear_Start.
- Output registers and the clear counter live in the top module.

## Test plan
- Reset: assert i_RST asynchronously during a stream of writes → all outputs 0 within the same cycle; after release, the first contended grant goes to Req0.
- Single write: Req0 Valid, addr 5, data 0xA → o_Req0_Ready = 1 in the same cycle; next cycle o_Wr_En = 1, o_Wr_Addr = 5, o_Wr_Data = 0xA; following cycle o_Wr_En = 0.
- Contention: both requesters Valid for 8 cycles with distinct addresses → grants R0,R1,R0,R1…; eight consecutive o_Wr_En cycles; each addr/data pair matches its requester.
- Clear (ADDR_DEPTH = 32, CLEAR_VALUE = 0, RAM preloaded with 0xF):
  - One-cycle start → Busy for 32 cycles; writes to addresses 0..31 in order; one Done pulse.
  - Reading all 32 RAM addresses afterwards returns 0.
- Collision: i_Clear_Start coincident with Req1 Valid (addr 3, data 0x7) → Req1 not Ready for 33 cycles; accepted on the cycle Done pulses; write to addr 3 lands after the clear, and RAM[3] reads 0x7.
- Reset mid-clear: assert i_RST when o_Wr_Addr = 10 → no Done; addresses 11..31 keep old data; a post-reset Req0 write is accepted normally.
